// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HIGH_CYCLES-wide pulses separated by at least GAP_CYCLES low cycles.
// Strobes that arrive during a pulse are queued. Define PULSE_STRETCHER_RETRIG_EN so a strobe during HIGH extends the current pulse.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 10,
    parameter int GAP_CYCLES  = 10,
    parameter int PEND_W      = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              Din,
    input  logic              clr_ovf,
    output logic              Dout,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              ovf
);

    localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CW-1:0]     H_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]     G_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] P_MAX  = '1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          retrig;
    logic          last_gap;
    logic          queue;

`ifdef PULSE_STRETCHER_RETRIG_EN
    assign retrig = (state == S_HIGH) && Din;
`else
    assign retrig = 1'b0;
`endif

    // A strobe on the final gap cycle either starts the next pulse itself or
    // cancels against the dequeued request, so it is never queued.
    assign last_gap = (state == S_GAP) && (cnt == '0);
    assign queue    = Din && (state != S_IDLE) && !retrig && !last_gap;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Dout    <= 1'b0;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            if (clr_ovf)
                ovf <= 1'b0;
            if (queue) begin
                if (pending == P_MAX)
                    ovf <= 1'b1;
                else
                    pending <= pending + 1'b1;
            end else if (last_gap && (pending != '0) && !Din) begin
                pending <= pending - 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (Din) begin
                        state <= S_HIGH;
                        cnt   <= H_LOAD;
                        Dout  <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (retrig) begin
                        cnt <= H_LOAD;
                    end else if (cnt == '0) begin
                        state <= S_GAP;
                        cnt   <= G_LOAD;
                        Dout  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        if ((pending != '0) || Din) begin
                            state <= S_HIGH;
                            cnt   <= H_LOAD;
                            Dout  <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    Dout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HIGH=4, GAP=2, PEND_W=2); expected waveforms are hand-computed bit strings.
module tb_pulse_stretcher;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       Din;
    logic       clr_ovf;
    logic       Dout;
    logic       busy;
    logic [1:0] pending;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2)) u_dut (
        .clk_in (clk_in),
        .reset  (reset),
        .Din    (Din),
        .clr_ovf(clr_ovf),
        .Dout   (Dout),
        .busy   (busy),
        .pending(pending),
        .ovf    (ovf)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic d, input logic c);
        Din     = d;
        clr_ovf = c;
        @(posedge clk_in);
        #1;
        Din     = 1'b0;
        clr_ovf = 1'b0;
    endtask

    // Applies dins MSB-first for n edges; records Dout/busy after each edge, first sample in the MSB.
    task automatic run(input logic [31:0] dins, input int n,
                       output logic [31:0] dv, output logic [31:0] bv);
        dv = '0;
        bv = '0;
        for (int i = 0; i < n; i++) begin
            tick(dins[n-1-i], 1'b0);
            dv = {dv[30:0], Dout};
            bv = {bv[30:0], busy};
        end
    endtask

    logic [31:0] dv, bv;
    int          pulses;
    logic        prev;

    initial begin
        reset   = 1'b1;
        Din     = 1'b1;
        clr_ovf = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("rst_dout", Dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf",  ovf, 0);
        reset = 1'b0;
        tick(1'b0, 1'b0);

        // single strobe from idle
        run(32'b1000_0000, 8, dv, bv);
        chk("t1_dout", dv, 32'b1111_0000);
        chk("t1_busy", bv, 32'b1111_1100);
        chk("t1_pend", pending, 0);

`ifdef PULSE_STRETCHER_RETRIG_EN
        // strobe during HIGH extends the pulse to 6 cycles
        run(32'b1010_0000_0, 9, dv, bv);
        chk("rt_dout", dv, 32'b1111_1100_0);
        chk("rt_busy", bv, 32'b1111_1111_0);
        chk("rt_pend", pending, 0);
        // strobe during GAP still queues
        run(32'b1000_01, 6, dv, bv);
        chk("rt_gapq", pending, 1);
        repeat (20) tick(1'b0, 1'b0);
        chk("rt_idle", busy, 0);
        chk("rt_pend0", pending, 0);
`else
        // strobes at relative edges 0, 2, 3 -> three back-to-back pulses
        run(32'b1011, 4, dv, bv);
        chk("t2a_dout", dv, 32'b1111);
        chk("t2a_pend", pending, 2);
        run(32'b000, 3, dv, bv);
        chk("t2b_dout", dv, 32'b001);
        chk("t2b_pend", pending, 1);
        run(32'b0, 13, dv, bv);
        chk("t2c_dout", dv, 32'b111_00_1111_0000);
        chk("t2c_busy", bv, 32'b111_1111_1111_00);
        chk("t2c_pend", pending, 0);

        // 6 consecutive strobes: saturate, overflow, clr_ovf loses to new overflow
        pulses = 0;
        prev   = 1'b0;
        for (int i = 0; i < 46; i++) begin
            tick(i < 6, i == 5);
            if (Dout && !prev) pulses++;
            prev = Dout;
            if (i == 3) begin
                chk("t3_pend_sat", pending, 3);
                chk("t3_ovf_pre", ovf, 0);
            end
            if (i == 4) chk("t3_ovf_set", ovf, 1);
            if (i == 5) chk("t3_ovf_setwins", ovf, 1);
        end
        chk("t3_pulses", pulses, 4);
        chk("t3_busy", busy, 0);
        chk("t3_pend", pending, 0);
        chk("t3_ovf_sticky", ovf, 1);
        tick(1'b0, 1'b1);
        chk("t3_ovf_clr", ovf, 0);

        // strobe exactly on the final GAP cycle with one pulse queued
        run(32'b1100_001, 7, dv, bv);
        chk("t4_dout", dv, 32'b1111_001);
        chk("t4_pend", pending, 1);
        run(32'b0, 14, dv, bv);
        chk("t4b_dout", dv, 32'b111_00_1111_00_000);
        chk("t4b_busy", bv, 32'b111_1111_1111_000);
        chk("t4b_pend", pending, 0);

        // reset mid-pulse with two queued
        run(32'b111, 3, dv, bv);
        chk("t5_pend_pre", pending, 2);
        reset = 1'b1;
        tick(1'b1, 1'b0);
        reset = 1'b0;
        chk("t5_dout", Dout, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pend", pending, 0);
        chk("t5_ovf",  ovf, 0);
        run(32'b0, 20, dv, bv);
        chk("t5_quiet", dv, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
